// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_scheduler: shares one UartTx between a buffered MMIO word path and a
// byte-wise DMA requester. Words are sent LSB byte first.
// Revision: 1.0
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int SEND_BUF_SIZE = 16,
  parameter int CNT_W         = $clog2(SEND_BUF_SIZE) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_en,
  input  logic [31:0]      push_data,
  input  logic             dma_req,
  input  logic [7:0]       dma_data,
  output logic             dma_ack,
  output logic             tx_start,
  output logic [7:0]       sdata,
  input  logic             tx_busy,
  output logic [CNT_W-1:0] free_words,
  output logic             buf_empty,
  output logic             overflow
);

  localparam int               PTR_W = $clog2(SEND_BUF_SIZE);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(SEND_BUF_SIZE);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_ACK  = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [31:0]      mem_q [SEND_BUF_SIZE];
  logic [1:0]       state_q, state_d;
  logic             src_dma_q, src_dma_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       sdata_q, sdata_d;

  logic             w_push_ok;
  logic             w_pop;
  logic [31:0]      w_rd_word;

  // Fullness is judged on registered occupancy, so a same-cycle pop never frees a slot.
  assign w_push_ok = push_en && (occ_q != DEPTH);
  assign w_pop     = (state_q == START) && !src_dma_q && (byte_idx_q == 2'd3);
  assign w_rd_word = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    src_dma_d  = src_dma_q;
    byte_idx_d = byte_idx_q;
    sdata_d    = sdata_q;
    case (state_q)
      IDLE: begin
        // DMA only wins at a word boundary, so a word is never split by DMA bytes.
        if (!tx_busy) begin
          if (dma_req && (byte_idx_q == 2'd0)) begin
            sdata_d   = dma_data;
            src_dma_d = 1'b1;
            state_d   = START;
          end else if ((occ_q != '0) || (byte_idx_q != 2'd0)) begin
            sdata_d   = w_rd_word[{byte_idx_q, 3'b000} +: 8];
            src_dma_d = 1'b0;
            state_d   = START;
          end
        end
      end
      START: begin
        if (!src_dma_q) begin
          byte_idx_d = byte_idx_q + 2'd1;
        end
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = w_push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = w_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d      = occ_q + CNT_W'(w_push_ok) - CNT_W'(w_pop);
    overflow_d = overflow_q | (push_en & ~w_push_ok);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      src_dma_q  <= 1'b0;
      byte_idx_q <= 2'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
      sdata_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      src_dma_q  <= src_dma_d;
      byte_idx_q <= byte_idx_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
      sdata_q    <= sdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push_ok && !reset) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign tx_start   = (state_q == START);
  assign dma_ack    = tx_start & src_dma_q;
  assign sdata      = sdata_q;
  assign free_words = DEPTH - occ_q;
  assign buf_empty  = (occ_q == '0);
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Owns the UartTx transmitter and shares it between two requesters: the core's MMIO send path and the boot-time DMA controller.
- Core writes to the UART send address are pushed as 32-bit words into an internal ring buffer.
- Each buffered word is serialized LSB-first as four bytes, using the UartTx tx_start/tx_busy handshake.
- Reports free buffer space so the MMIO read at 0xfffffff8 returns the sendable word count instead of a bare ~tx_busy.

Parameters:
- SEND_BUF_SIZE, 16: number of 32-bit word entries in the send ring buffer. Must be a power of two, at least 2.
- CNT_W, $clog2(SEND_BUF_SIZE)+1: width of the occupancy and free-space counters.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- push_en  input  1  core MMIO write to the send address (addr[31] & addr[2] & we & en).
- push_data  input  32  word to enqueue. Byte 0 = push_data[7:0] is sent first.
- dma_req  input  1  DMA controller requests one byte; held high until dma_ack.
- dma_data  input  8  byte from the DMA controller; stable while dma_req is high.
- dma_ack  output  1  one-cycle pulse: the DMA byte has been issued to UartTx.
- tx_start  output  1  one-cycle start pulse to UartTx.
- sdata  output  8  byte to UartTx; held stable from tx_start until tx_busy falls.
- tx_busy  input  1  UartTx busy flag.
- free_words  output  CNT_W  SEND_BUF_SIZE minus current occupancy.
- buf_empty  output  1  occupancy == 0.
- overflow  output  1  sticky: a push was dropped because the buffer was full.

Behaviour:
- Clock and reset: one clock, reset is synchronous and active-high. The ports are named clock and reset, as in the rest of the codebase.
- Reset values: tx_start=0, sdata=0, dma_ack=0, overflow=0, occupancy=0, rd/wr pointers=0, byte_idx=0, state=IDLE. Hence free_words=SEND_BUF_SIZE and buf_empty=1.
- Reset mid-transfer aborts immediately: buffered words are discarded and no further tx_start is issued. UartTx finishes its current frame on its own.
- Buffer storage is LUT/register based. Pointers wrap modulo SEND_BUF_SIZE.
- Push:
  - Accepted when registered occupancy < SEND_BUF_SIZE; the word is written at wr_ptr and wr_ptr advances.
  - Push while full is dropped and sets overflow=1. This holds even if a pop happens in the same cycle.
- Pop happens in the cycle tx_start is issued for byte_idx==3. rd_ptr advances and byte_idx returns to 0.
- Push and pop in the same cycle (not full): occupancy is unchanged and both pointers advance.
- FSM states:
  - IDLE:
    - If dma_req=1 and byte_idx==0: sdata<=dma_data, go to START with source=DMA.
    - Else if occupancy>0 or byte_idx!=0: sdata<=buf[rd_ptr] byte byte_idx, go to START with source=BUF.
    - Else stay in IDLE.
  - START:
    - tx_start=1 for exactly this cycle.
    - If source=DMA, dma_ack=1 in the same cycle.
    - If source=BUF, byte_idx<=byte_idx+1 (mod 4), with the pop rule above.
    - Go to WAIT_ACK.
  - WAIT_ACK: stay until tx_busy=1, then go to WAIT_DONE. This covers UartTx asserting busy one or more cycles after tx_start.
  - WAIT_DONE: stay until tx_busy=0, then go to IDLE.
- Consecutive bytes are separated by at least one IDLE cycle. Minimum tx_start-to-tx_start spacing is therefore 4 cycles plus the UartTx busy time.
- Arbitration:
  - DMA has fixed priority, but is granted only at word boundaries (byte_idx==0). A buffered word is never interleaved with DMA bytes.
  - A DMA request that arrives mid-word waits until byte 3 of that word is issued.
- A byte is issued only from IDLE, never while tx_busy=1 is observed in IDLE. If tx_busy=1 in IDLE (busy left over from a pre-reset frame), stay in IDLE.
- sdata is loaded only on the IDLE->START transition.
- free_words and buf_empty are combinational from the registered occupancy. A pop in cycle N is visible in cycle N+1.

Test Plan:
- Reset, then push 0x44332211 with UartTx model busy for 10 cycles per byte -> tx_start pulses with sdata 0x11, 0x22, 0x33, 0x44 in that order. free_words goes 16->15 after the push and back to 16 after the byte-3 tx_start. buf_empty=1 at the end.
- Push 17 words back-to-back with tx_busy forced 1 -> first 16 accepted, free_words=0. 17th dropped, overflow=1. Release tx_busy -> exactly 64 bytes sent, in push order, with correct pointer wrap.
- dma_req with dma_data=0xA5 while the buffer is sending byte 1 of 0xDDCCBBAA -> bytes sent are 0xBB, 0xCC, 0xDD, then 0xA5. dma_ack pulses once, in the cycle tx_start carries 0xA5.
- Buffer holds one word and dma_req=1 arrive together in IDLE -> 0xA5 is sent first, then the four buffered bytes.
- At occupancy 15, push in the same cycle as a byte-3 pop -> push accepted, occupancy stays 15, no overflow. At occupancy 16 with a simultaneous pop -> push dropped, overflow=1, occupancy becomes 15.
- Assert reset in WAIT_DONE after byte 1 of a word -> next cycle: free_words=16, tx_start=0, overflow=0, sdata=0. No further bytes are sent after tx_busy falls.
